// File: rtl/mt9v032_regcfg_if.sv
// rtl/mt9v032_regcfg_if.sv - two-wire write command/response bus
//
// Purpose: carries register write commands from the sequencer to the
//          two-wire master and the per-transaction response back.
// Signals:
//   cmd_valid / cmd_ready : command handshake (sequencer -> master)
//   cmd_dev               : 7-bit device address
//   cmd_reg               : 8-bit register address
//   cmd_data              : 16-bit register value
//   rsp_valid             : one-cycle pulse, transaction finished
//   rsp_nack              : qualified by rsp_valid, 1 = NACK
// Modports:
//   master : the sequencer side (drives commands)
//   slave  : the two-wire master side (accepts commands, returns responses)
interface mt9v032_regcfg_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_dev;
  logic [7:0]  cmd_reg;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_nack;

  modport master (
    output cmd_valid, cmd_dev, cmd_reg, cmd_data,
    input  cmd_ready, rsp_valid, rsp_nack
  );

  modport slave (
    input  cmd_valid, cmd_dev, cmd_reg, cmd_data,
    output cmd_ready, rsp_valid, rsp_nack
  );
endinterface

// File: rtl/mt9v032_regcfg.sv
// rtl/mt9v032_regcfg.sv - MT9V032 register table sequencer
//
// Purpose: after a power-up delay, walks a register table held in a
//          synchronous ROM and writes each entry to the sensor through a
//          two-wire master, retrying NACKed writes a bounded number of times.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : single-cycle request to run the table (honoured only when idle)
//   tbl_addr  : ROM index; tbl_data ({reg, value}) is valid one cycle later
//   bus       : command/response bus, master modport
//   busy      : sequence in progress
//   done      : table completed without error (sticky until next start)
//   error     : retries exhausted (sticky until next start)
//   err_idx   : index of the entry that failed
module mt9v032_regcfg #(
  parameter int         DEPTH      = 16,
  parameter int         RETRIES    = 3,
  parameter logic [6:0] DEV_ADDR   = 7'h48,
  parameter int         PWR_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [7:0]             tbl_addr,
  input  logic [23:0]            tbl_data,
  mt9v032_regcfg_if.master       bus,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [7:0]             err_idx
);

  localparam logic [7:0]  LAST_IDX  = 8'(DEPTH - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(RETRIES);
  localparam logic [15:0] PWR_LAST  = 16'(PWR_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PWR, S_FETCH, S_LATCH, S_ISSUE, S_WAIT, S_NEXT, S_FIN, S_FAIL
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pwr_cnt_q, pwr_cnt_d;
  logic [3:0]  retry_q, retry_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  cmd_reg_q, cmd_reg_d;
  logic [15:0] cmd_data_q, cmd_data_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [7:0]  err_idx_q, err_idx_d;

  always_comb begin
    state_d    = state_q;
    pwr_cnt_d  = pwr_cnt_q;
    retry_d    = retry_q;
    idx_d      = idx_q;
    cmd_reg_d  = cmd_reg_q;
    cmd_data_d = cmd_data_q;
    done_d     = done_q;
    error_d    = error_q;
    err_idx_d  = err_idx_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          done_d    = 1'b0;
          error_d   = 1'b0;
          err_idx_d = 8'd0;
          idx_d     = 8'd0;
          pwr_cnt_d = 16'd0;
          state_d   = S_PWR;
        end
      end
      S_PWR: begin
        if (pwr_cnt_q == PWR_LAST) state_d = S_FETCH;
        else                       pwr_cnt_d = pwr_cnt_q + 16'd1;
      end
      // tbl_addr already equals the index here; the ROM answers next cycle.
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        cmd_reg_d  = tbl_data[23:16];
        cmd_data_d = tbl_data[15:0];
        retry_d    = 4'd0;
        state_d    = S_ISSUE;
      end
      S_ISSUE: begin
        if (bus.cmd_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.rsp_valid) begin
          if (!bus.rsp_nack) begin
            state_d = S_NEXT;
          end else if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 4'd1;
            state_d = S_ISSUE;
          end else begin
            err_idx_d = idx_q;
            state_d   = S_FAIL;
          end
        end
      end
      S_NEXT: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_FIN;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_FETCH;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_FAIL: begin
        error_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Derived from the next state so the registered flags track state_q exactly.
    busy_d      = (state_d != S_IDLE);
    cmd_valid_d = (state_d == S_ISSUE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pwr_cnt_q   <= 16'd0;
      retry_q     <= 4'd0;
      idx_q       <= 8'd0;
      cmd_reg_q   <= 8'd0;
      cmd_data_q  <= 16'd0;
      cmd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_idx_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      pwr_cnt_q   <= pwr_cnt_d;
      retry_q     <= retry_d;
      idx_q       <= idx_d;
      cmd_reg_q   <= cmd_reg_d;
      cmd_data_q  <= cmd_data_d;
      cmd_valid_q <= cmd_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_idx_q   <= err_idx_d;
    end
  end

  assign tbl_addr      = idx_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_dev   = DEV_ADDR;
  assign bus.cmd_reg   = cmd_reg_q;
  assign bus.cmd_data  = cmd_data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_idx       = err_idx_q;

endmodule

// File: tb/tb_mt9v032_regcfg.sv
// tb/tb_mt9v032_regcfg.sv - directed bench for mt9v032_regcfg
module tb_mt9v032_regcfg;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  tbl_addr;
  logic [23:0] tbl_data;
  logic        busy, done, error;
  logic [7:0]  err_idx;
  logic [23:0] rom [0:3];

  int vectors = 0;
  int miscompares = 0;

  mt9v032_regcfg_if bus_if ();

  mt9v032_regcfg #(
    .DEPTH(4), .RETRIES(3), .DEV_ADDR(7'h48), .PWR_CYCLES(10)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .bus(bus_if.master),
    .busy(busy), .done(done), .error(error), .err_idx(err_idx)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data follows the address by one clock.
  always_ff @(posedge clk) tbl_data <= rom[tbl_addr[1:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cmd_valid"}, bus_if.cmd_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_tbl_addr"}, tbl_addr, 0);
    chk({tag, "_err_idx"}, err_idx, 0);
    chk({tag, "_cmd_reg"}, bus_if.cmd_reg, 0);
    chk({tag, "_cmd_data"}, bus_if.cmd_data, 0);
  endtask

  // Pulse start; returns cycles from the start cycle to the first cmd_valid.
  task automatic pulse_start(output int lat);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!bus_if.cmd_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Wait for a command, check its contents, accept it and optionally respond.
  task automatic serve(input string tag, input logic [23:0] exp,
                       input bit respond, input bit nack);
    int n = 0;
    while (!bus_if.cmd_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_seen"}, bus_if.cmd_valid, 1);
    chk({tag, "_reg"}, bus_if.cmd_reg, exp[23:16]);
    chk({tag, "_data"}, bus_if.cmd_data, exp[15:0]);
    bus_if.cmd_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_vdrop"}, bus_if.cmd_valid, 0);
    if (respond) begin
      bus_if.rsp_valid = 1'b1;
      bus_if.rsp_nack  = nack;
      @(negedge clk);
      bus_if.rsp_valid = 1'b0;
      bus_if.rsp_nack  = 1'b0;
    end
  endtask

  // Wait for the sequence to finish; returns commands seen meanwhile.
  task automatic wait_idle(input string tag, output int extra);
    int n = 0;
    extra = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      if (bus_if.cmd_valid) extra++;
      n++;
    end
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int lat;
    int extra;
    int stable;
    logic [7:0]  r0;
    logic [15:0] d0;

    rom[0] = {8'h07, 16'h0388};
    rom[1] = {8'h0D, 16'h0300};
    rom[2] = {8'h35, 16'h0010};
    rom[3] = {8'hAF, 16'h0003};

    rst = 1'b1;
    start = 1'b0;
    bus_if.cmd_ready = 1'b1;
    bus_if.rsp_valid = 1'b0;
    bus_if.rsp_nack  = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // All entries ACK: order, contents, latency and completion flags.
    pulse_start(lat);
    chk("latency", lat, 13);
    chk("cmd_dev", bus_if.cmd_dev, 7'h48);
    serve("ack_e0", rom[0], 1, 0);
    serve("ack_e1", rom[1], 1, 0);
    serve("ack_e2", rom[2], 1, 0);
    serve("ack_e3", rom[3], 1, 0);
    wait_idle("ack", extra);
    chk("ack_done", done, 1);
    chk("ack_error", error, 0);
    chk("ack_extra", extra, 0);

    // Ready held low 20 cycles; stray start and response while in ISSUE.
    bus_if.cmd_ready = 1'b0;
    pulse_start(lat);
    chk("stall_done_cleared", done, 0);
    r0 = bus_if.cmd_reg;
    d0 = bus_if.cmd_data;
    stable = 0;
    for (int i = 0; i < 20; i++) begin
      start = (i == 5);
      bus_if.rsp_valid = (i == 10);
      @(negedge clk);
      if (bus_if.cmd_valid && bus_if.cmd_reg == r0 && bus_if.cmd_data == d0) stable++;
    end
    start = 1'b0;
    bus_if.rsp_valid = 1'b0;
    chk("stall_stable", stable, 20);
    chk("stall_tbl_addr", tbl_addr, 0);
    serve("stall_e0", rom[0], 1, 0);
    serve("stall_e1", rom[1], 1, 0);
    serve("stall_e2", rom[2], 1, 0);
    serve("stall_e3", rom[3], 1, 0);
    wait_idle("stall", extra);
    chk("stall_done", done, 1);
    chk("stall_extra", extra, 0);

    // Entry 2 NACKs twice, then ACKs.
    pulse_start(lat);
    serve("rty_e0", rom[0], 1, 0);
    serve("rty_e1", rom[1], 1, 0);
    serve("rty_e2a", rom[2], 1, 1);
    serve("rty_e2b", rom[2], 1, 1);
    serve("rty_e2c", rom[2], 1, 0);
    serve("rty_e3", rom[3], 1, 0);
    wait_idle("rty", extra);
    chk("rty_done", done, 1);
    chk("rty_error", error, 0);

    // Entry 1 always NACKs: four attempts, then error.
    pulse_start(lat);
    serve("nack_e0", rom[0], 1, 0);
    serve("nack_e1a", rom[1], 1, 1);
    serve("nack_e1b", rom[1], 1, 1);
    serve("nack_e1c", rom[1], 1, 1);
    serve("nack_e1d", rom[1], 1, 1);
    wait_idle("nack", extra);
    chk("nack_error", error, 1);
    chk("nack_err_idx", err_idx, 1);
    chk("nack_done", done, 0);
    chk("nack_extra", extra, 0);

    // Reset while waiting on entry 1, then a clean rerun from index 0.
    pulse_start(lat);
    chk("rerun_error_cleared", error, 0);
    serve("rst_e0", rom[0], 1, 0);
    serve("rst_e1", rom[1], 0, 0);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_stays_idle", busy, 0);
    pulse_start(lat);
    chk("rerun_latency", lat, 13);
    serve("rerun_e0", rom[0], 1, 0);
    serve("rerun_e1", rom[1], 1, 0);
    serve("rerun_e2", rom[2], 1, 0);
    serve("rerun_e3", rom[3], 1, 0);
    wait_idle("rerun", extra);
    chk("rerun_done", done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
